// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel compute path.
// Holds the default frame geometry (also used by the display path) and the
// frame sequencer state type.
package pixel_pkg;

    localparam int unsigned H_RES_DEFAULT = 1024;
    localparam int unsigned V_RES_DEFAULT = 768;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/pixel_scheduler_if.sv
// Job / result / frame-buffer bundle between the frame sequencer and its
// neighbours.
//   master : scheduler side (drives job_*, fb_*; receives job_ready, res_*)
//   slave  : engine / frame buffer side
interface pixel_scheduler_if
    import pixel_pkg::*;
#(
    parameter int unsigned X_W    = $clog2(H_RES_DEFAULT),
    parameter int unsigned Y_W    = $clog2(V_RES_DEFAULT),
    parameter int unsigned ADDR_W = $clog2(H_RES_DEFAULT * V_RES_DEFAULT),
    parameter int unsigned DATA_W = 8
);

    logic              job_valid;
    logic              job_ready;
    logic [X_W-1:0]    job_x;
    logic [Y_W-1:0]    job_y;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;

    modport master (
        output job_valid, job_x, job_y, fb_we, fb_addr, fb_data,
        input  job_ready, res_valid, res_data
    );

    modport slave (
        input  job_valid, job_x, job_y, fb_we, fb_addr, fb_data,
        output job_ready, res_valid, res_data
    );

endinterface

// File: rtl/pixel_counter.sv
// Raster-order (X,Y) counter for one frame.
//   clk, rst : clock, synchronous active-low reset
//   clr_i    : clear X and Y to 0 (wins over en_i)
//   en_i     : advance one pixel; X wraps at H_RES-1 and carries into Y
//   x_o, y_o : current coordinate
//   last_o   : current coordinate is the last pixel of the frame
module pixel_counter
    import pixel_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEFAULT,
    parameter int unsigned V_RES = V_RES_DEFAULT,
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] XMax = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YMax = Y_W'(V_RES - 1);

    logic [X_W-1:0] x_d, x_q;
    logic [Y_W-1:0] y_d, y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            // Wrap at the line length, not at the counter width.
            if (x_q == XMax) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XMax) && (y_q == YMax);

endmodule

// File: rtl/pixel_scheduler.sv
// Frame-level sequencer: walks every (X,Y) of a frame in raster order, issues
// each coordinate as a job to the compute engine, waits for its result and
// writes it to the frame buffer. One job in flight at a time.
//   clk, rst     : clock, synchronous active-low reset
//   start        : begin a frame (only honoured while idle)
//   abort        : cancel the current frame
//   busy         : high whenever not idle
//   done         : one-cycle pulse after the last pixel is written
//   bus (master) : job_valid/job_ready/job_x/job_y to the engine,
//                  res_valid/res_data from the engine,
//                  fb_we/fb_addr/fb_data to the frame buffer
module pixel_scheduler
    import pixel_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEFAULT,
    parameter int unsigned V_RES  = V_RES_DEFAULT,
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    pixel_scheduler_if.master  bus
);

    sched_state_t      state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] fb_data_d, fb_data_q;
    logic              busy_q, done_q, job_valid_q, fb_we_q;

    logic              cnt_clr, cnt_en, cnt_last;
    logic [X_W-1:0]    cnt_x;
    logic [Y_W-1:0]    cnt_y;

    pixel_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .x_o    (cnt_x),
        .y_o    (cnt_y),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        fb_data_d = fb_data_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    cnt_clr = 1'b1;
                    addr_d  = '0;
                end
            end
            ISSUE: begin
                // job_valid is registered high for the whole of ISSUE, so
                // job_ready alone marks the transfer cycle.
                if (abort) begin
                    state_d = IDLE;
                end else if (bus.job_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A result landing with the abort is already consumed, so
                // there is nothing left to drain.
                if (abort) begin
                    state_d = bus.res_valid ? IDLE : DRAIN;
                end else if (bus.res_valid) begin
                    state_d   = WRITE;
                    fb_data_d = bus.res_data;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    cnt_en  = 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (bus.res_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            fb_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            job_valid_q <= 1'b0;
            fb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fb_data_q   <= fb_data_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            job_valid_q <= (state_d == ISSUE);
            fb_we_q     <= (state_d == WRITE);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.job_valid = job_valid_q;
    assign bus.job_x     = cnt_x;
    assign bus.job_y     = cnt_y;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = addr_q;
    assign bus.fb_data   = fb_data_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Self-checking bench for pixel_scheduler on a 4x3 frame. A behavioural
// engine answers each accepted job after a (fixed or random) latency with
// ((x + H*y) ^ salt); the expected frame is rebuilt from raster order.
module tb_pixel_scheduler;

    localparam int unsigned H      = 4;
    localparam int unsigned V      = 3;
    localparam int unsigned XW     = 2;
    localparam int unsigned YW     = 2;
    localparam int unsigned AW     = 4;
    localparam int unsigned DW     = 8;
    localparam int          NPIX   = H * V;
    localparam int          BUDGET = 2000;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    pixel_scheduler_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    pixel_scheduler #(
        .H_RES  (H),
        .V_RES  (V),
        .X_W    (XW),
        .Y_W    (YW),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          eng_cnt     = 0;
    int          eng_x       = 0;
    int          eng_y       = 0;
    int          stall       = 0;
    int          fixed_lat   = 2;
    bit          ready_rand  = 1'b0;
    bit          lat_rand    = 1'b0;
    bit          bp_arm      = 1'b0;
    bit          bp_watch    = 1'b0;
    bit          spur_arm    = 1'b0;
    logic [7:0]  salt        = 8'h00;
    int          done_cnt    = 0;
    int          done_cyc    = -1;
    int          last_wr_cyc = -1;

    int wr_addr_q[$];
    int wr_data_q[$];
    int job_x_q[$];
    int job_y_q[$];

    function automatic logic [7:0] exp_data(input int x, input int y, input logic [7:0] s);
        return 8'(x + H * y) ^ s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then drive the engine inputs
    // for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.fb_we === 1'b1) begin
            wr_addr_q.push_back(int'(bus.fb_addr));
            wr_data_q.push_back(int'(bus.fb_data));
            if (int'(bus.fb_addr) == NPIX - 1) last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        bus.res_valid = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bus.res_valid = 1'b1;
                bus.res_data  = exp_data(eng_x, eng_y, salt);
            end
        end
        // Illegal result pulse while a job is still being offered.
        if (spur_arm && bus.job_valid === 1'b1 && eng_cnt == 0 && !bus.res_valid) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 8'hEE;
            spur_arm      = 1'b0;
            if (stall < 1) stall = 1;
        end
        if (bp_arm && bus.job_valid === 1'b1 && int'(bus.job_x) == 2 && int'(bus.job_y) == 1) begin
            stall    = 5;
            bp_arm   = 1'b0;
            bp_watch = 1'b1;
        end
        if (stall > 0) begin
            if (bp_watch) begin
                check("bp_valid", 32'(bus.job_valid), 1);
                check("bp_x", 32'(bus.job_x), 2);
                check("bp_y", 32'(bus.job_y), 1);
            end
            stall--;
            bus.job_ready = 1'b0;
        end else begin
            bp_watch      = 1'b0;
            bus.job_ready = ready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        if (bus.job_valid === 1'b1 && bus.job_ready) begin
            job_x_q.push_back(int'(bus.job_x));
            job_y_q.push_back(int'(bus.job_y));
            eng_x   = int'(bus.job_x);
            eng_y   = int'(bus.job_y);
            eng_cnt = lat_rand ? int'($urandom_range(4, 1)) : fixed_lat;
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        job_x_q.delete();
        job_y_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        last_wr_cyc = -1;
    endtask

    task automatic check_frame(input string tag);
        int n;
        check({tag, "_nwr"}, wr_addr_q.size(), NPIX);
        check({tag, "_njob"}, job_x_q.size(), NPIX);
        n = (wr_addr_q.size() < NPIX) ? wr_addr_q.size() : NPIX;
        for (int k = 0; k < n; k++) begin
            check({tag, "_addr"}, wr_addr_q[k], k);
            check({tag, "_data"}, wr_data_q[k], 32'(exp_data(k % H, k / H, salt)));
        end
        n = (job_x_q.size() < NPIX) ? job_x_q.size() : NPIX;
        for (int k = 0; k < n; k++) begin
            check({tag, "_jx"}, job_x_q[k], k % H);
            check({tag, "_jy"}, job_y_q[k], k / H);
        end
        check({tag, "_ndone"}, done_cnt, 1);
        check({tag, "_done_lag"}, done_cyc - last_wr_cyc, 1);
    endtask

    // Start a frame (start held for 'hold' cycles), run it to done, check it.
    task automatic run_frame(input string tag, input int hold);
        int n;
        clear_log();
        start = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_in_time"}, 32'(n < BUDGET), 1);
        tick();
        check({tag, "_idle"}, 32'(busy), 0);
        check_frame(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_jv"}, 32'(bus.job_valid), 0);
        check({tag, "_we"}, 32'(bus.fb_we), 0);
        check({tag, "_addr"}, 32'(bus.fb_addr), 0);
        check({tag, "_jx"}, 32'(bus.job_x), 0);
        check({tag, "_jy"}, 32'(bus.job_y), 0);
        check({tag, "_fbd"}, 32'(bus.fb_data), 0);
    endtask

    initial begin
        int n;
        bus.job_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;

        // Reset held for two cycles.
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check("reset_stay_idle", 32'(busy), 0);

        // Plain frame: always ready, latency 2, data equals the address.
        fixed_lat  = 2;
        salt       = 8'h00;
        run_frame("frame", 1);

        // Backpressure on pixel (2,1).
        salt   = 8'($urandom);
        bp_arm = 1'b1;
        run_frame("bp", 1);
        check("bp_consumed", 32'(bp_arm), 0);

        // Abort while waiting on pixel (1,0).
        clear_log();
        fixed_lat = 4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (job_x_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach", 32'(n < 100), 1);
        tick();
        abort = 1'b1;
        tick();
        check("abort_drain_busy", 32'(busy), 1);
        check("abort_drain_jv", 32'(bus.job_valid), 0);
        tick();
        abort = 1'b0;
        check("abort_drain_busy2", 32'(busy), 1);
        tick();
        check("abort_drain_busy3", 32'(busy), 1);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("abort_idle", 32'(busy), 0);
        check("abort_nwr", wr_addr_q.size(), 1);
        check("abort_njob", job_x_q.size(), 2);
        check("abort_no_done", done_cnt, 0);
        repeat (3) tick();
        check("abort_still_nwr", wr_addr_q.size(), 1);

        // Restart after abort with random ready and latency.
        ready_rand = 1'b1;
        lat_rand   = 1'b1;
        salt       = 8'($urandom);
        run_frame("restart", 1);

        // start held mid-frame plus an illegal result during ISSUE.
        salt     = 8'($urandom);
        spur_arm = 1'b1;
        run_frame("spur", 10);
        check("spur_fired", 32'(spur_arm), 0);

        // Reset during the write of pixel (3,1).
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(bus.fb_we === 1'b1 && int'(bus.fb_addr) == 7) && n < BUDGET) begin
            tick();
            n++;
        end
        check("rst_reach", 32'(n < BUDGET), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("midrst");
        eng_cnt = 0;
        stall   = 0;
        salt    = 8'($urandom);
        run_frame("after_rst", 1);

        // A few more random frames.
        for (int f = 0; f < 3; f++) begin
            salt = 8'($urandom);
            run_frame("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
